// File: rtl/mandelbrot_iter_unit_pkg.sv
// ----------------------------------------------------------------------------
// mandelbrot_pkg
// Shared definitions for the Mandelbrot iteration engine.
//   state_t    : engine state encoding (IDLE, RUN, DONE)
//   FRAC_BITS  : fraction bits of the default 8-bit 2.6 coordinate format
//   ONE        : 1.0 in that format
//   FOUR_SQ    : 4.0 in the format of a product of two coordinates
//   frac_bits(): fraction bits for any coordinate width
// ----------------------------------------------------------------------------
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32'sd8;
  localparam int FRAC_BITS = WIDTH_DEF - 32'sd2;
  localparam int ONE       = 32'sd1 <<< FRAC_BITS;
  localparam int FOUR_SQ   = 32'sd4 <<< (32'sd2 * FRAC_BITS);

  // Coordinates are 2.(width-2): two integer bits including the sign.
  function automatic int frac_bits(input int width);
    return width - 32'sd2;
  endfunction

endpackage

// File: rtl/mandelbrot_iter_unit_if.sv
// ----------------------------------------------------------------------------
// mandelbrot_iter_unit_if
// Request/result handshake bundle of the Mandelbrot iteration engine.
//   in_valid/in_ready      : request handshake carrying in_cr, in_ci, in_max_iter
//   out_valid/out_ready    : result handshake carrying out_iter, out_escaped,
//                            out_overflow
//   busy                   : engine is iterating
// Modports: master = coordinate generator / consumer side, slave = engine.
// ----------------------------------------------------------------------------
interface mandelbrot_iter_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_cr;
  logic signed [WIDTH-1:0] in_ci;
  logic [CNT_W-1:0]        in_max_iter;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        out_iter;
  logic                    out_escaped;
  logic                    out_overflow;
  logic                    busy;

  modport slave (
    input  in_valid, in_cr, in_ci, in_max_iter, out_ready,
    output in_ready, out_valid, out_iter, out_escaped, out_overflow, busy
  );

  modport master (
    output in_valid, in_cr, in_ci, in_max_iter, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped, out_overflow, busy
  );

endinterface

// File: rtl/mandelbrot_iter_unit_step.sv
// ----------------------------------------------------------------------------
// mandelbrot_step
// One combinational Mandelbrot step on 2.(WIDTH-2) fixed-point values.
//   cr, ci         : point c
//   zr, zi         : current z
//   zr_next/zi_next: z^2 + c, truncated (LSBs dropped) and wrapped modulo 4
//   escape         : |z|^2 > 4.0 on the current z, full precision
//   overflow       : (only with MANDELBROT_OVERFLOW_DETECT_EN) z^2 + c before
//                    truncation lies outside [-2, 2)
// ----------------------------------------------------------------------------
module mandelbrot_step
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  output logic signed [WIDTH-1:0] zr_next,
  output logic signed [WIDTH-1:0] zi_next,
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
  output logic                    overflow,
`endif
  output logic                    escape
);

  localparam int FRAC = frac_bits(WIDTH);
  localparam int MW   = 2 * WIDTH;       // product width, 4.(2*FRAC)
  localparam int SQW  = 2 * WIDTH + 1;   // |z|^2 without truncation
  // Wide enough that 2*zr*zi + ci never wraps before the range check.
  localparam int EW   = 2 * WIDTH + 3;
  localparam logic signed [SQW-1:0] FOUR_SQ_W = SQW'(64'sd4 <<< (2 * FRAC));

  logic signed [MW-1:0]    m_rr;
  logic signed [MW-1:0]    m_ii;
  logic signed [MW-1:0]    m_ri;
  logic signed [SQW-1:0]   sq;
  logic signed [EW-1:0]    sum_r;
  logic signed [EW-1:0]    sum_i;
  logic signed [EW-1:0]    sh_r;
  logic signed [EW-1:0]    sh_i;
  logic signed [WIDTH-1:0] tr_r;
  logic signed [WIDTH-1:0] tr_i;

  assign m_rr = MW'(zr) * MW'(zr);
  assign m_ii = MW'(zi) * MW'(zi);
  assign m_ri = MW'(zr) * MW'(zi);

  assign sq     = SQW'(m_rr) + SQW'(m_ii);
  assign escape = (sq > FOUR_SQ_W);

  // c is shifted up to the product's fraction alignment before adding.
  assign sum_r = EW'(m_rr) - EW'(m_ii) + (EW'(cr) <<< FRAC);
  assign sum_i = (EW'(m_ri) <<< 32'd1) + (EW'(ci) <<< FRAC);

  // Arithmetic shift = truncation toward minus infinity; narrowing wraps mod 4.
  assign sh_r = sum_r >>> FRAC;
  assign sh_i = sum_i >>> FRAC;
  assign tr_r = WIDTH'(sh_r);
  assign tr_i = WIDTH'(sh_i);

  assign zr_next = tr_r;
  assign zi_next = tr_i;

`ifdef MANDELBROT_OVERFLOW_DETECT_EN
  // Out of range exactly when the wrapped value no longer sign-extends back.
  assign overflow = (sh_r != EW'(tr_r)) || (sh_i != EW'(tr_i));
`endif

endmodule

// File: rtl/mandelbrot_iter_unit.sv
// ----------------------------------------------------------------------------
// mandelbrot_iter_unit
// Sequential Mandelbrot pixel engine: accepts c over a valid/ready request,
// iterates z <- z^2 + c from z = 0 one step per cycle, and returns the number
// of z updates over a valid/ready result handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mandelbrot_iter_unit_if.slave (request, result, busy)
// Optional build macro MANDELBROT_OVERFLOW_DETECT_EN: an update leaving
// [-2, 2) terminates the pixel as escaped with out_overflow set; without it
// out-of-range values wrap modulo 4 and out_overflow is tied low.
// ----------------------------------------------------------------------------
module mandelbrot_iter_unit
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mandelbrot_iter_unit_if.slave bus
);

  state_t                  state;
  logic signed [WIDTH-1:0] zr;
  logic signed [WIDTH-1:0] zi;
  logic signed [WIDTH-1:0] cr;
  logic signed [WIDTH-1:0] ci;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        limit;
  logic [CNT_W-1:0]        res_iter;
  logic                    res_esc;
  logic                    busy;

  logic signed [WIDTH-1:0] zr_next;
  logic signed [WIDTH-1:0] zi_next;
  logic                    step_esc;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
  logic                    step_ovf;
  logic                    res_ovf;
`endif

  mandelbrot_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cr       (cr),
    .ci       (ci),
    .zr       (zr),
    .zi       (zi),
    .zr_next  (zr_next),
    .zi_next  (zi_next),
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
    .overflow (step_ovf),
`endif
    .escape   (step_esc)
  );

  // Engine FSM: request capture, one iteration step per RUN cycle, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      zr       <= '0;
      zi       <= '0;
      cr       <= '0;
      ci       <= '0;
      cnt      <= '0;
      limit    <= '0;
      res_iter <= '0;
      res_esc  <= 1'b0;
      busy     <= 1'b0;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
      res_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cr    <= bus.in_cr;
            ci    <= bus.in_ci;
            limit <= bus.in_max_iter;
            zr    <= '0;
            zi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Escape test and limit test look at the current z, before updating.
          if (step_esc) begin
            res_iter <= cnt;
            res_esc  <= 1'b1;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
            res_ovf  <= 1'b0;
`endif
            busy     <= 1'b0;
            state    <= DONE;
          end else if (cnt == limit) begin
            res_iter <= cnt;
            res_esc  <= 1'b0;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
            res_ovf  <= 1'b0;
`endif
            busy     <= 1'b0;
            state    <= DONE;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
          end else if (step_ovf) begin
            // The discarded update still counts; cnt < limit so no wrap.
            res_iter <= cnt + CNT_W'(32'd1);
            res_esc  <= 1'b1;
            res_ovf  <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
`endif
          end else begin
            zr  <= zr_next;
            zi  <= zi_next;
            cnt <= cnt + CNT_W'(32'd1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_iter    = res_iter;
  assign bus.out_escaped = res_esc;
  assign bus.busy        = busy;
`ifdef MANDELBROT_OVERFLOW_DETECT_EN
  assign bus.out_overflow = res_ovf;
`else
  assign bus.out_overflow = 1'b0;
`endif

endmodule

// File: doc/mandelbrot_iter_unit.md
Name: mandelbrot_iter_unit

Overview:
- Sequential Mandelbrot pixel engine: accepts one point c = (cr, ci) over a valid/ready handshake and iterates z <- z^2 + c from z = 0.
- Stops on escape, on overflow (optional), or on a per-request iteration limit, then returns the iteration count over a valid/ready handshake.
- Sits between the pixel/coordinate generator and the colour mapper; generalises the combinational single-step ALU to width-parametrised, multi-cycle, flow-controlled operation.

Parameters:
- WIDTH, 8, bits per coordinate; fixed-point format 2.(WIDTH-2), two's complement, range [-2, 2).
- CNT_W, 4, width of the iteration limit and iteration count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- in_cr  in  WIDTH  real part of c.
- in_ci  in  WIDTH  imaginary part of c.
- in_max_iter  in  CNT_W  iteration limit for this request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_iter  out  CNT_W  number of z updates performed.
- out_escaped  out  1  point escaped (|z|^2 > 4, or overflow).
- out_overflow  out  1  escape caused by range overflow.
- busy  out  1  engine is in RUN.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-RUN): state = IDLE; z, c, cnt, limit and all result registers = 0; in_ready = 1; out_valid = 0; busy = 0.
- IDLE: in_ready = 1. On in_valid & in_ready, latch cr, ci and in_max_iter; set z = 0, cnt = 0; go to RUN.
- RUN: exactly one step per cycle.
  - Squares: m_rr = zr*zr, m_ii = zi*zi, m_ri = zr*zi, each signed 2*WIDTH bits.
  - Escape test on the current z: sq = m_rr + m_ii, full precision, no truncation; escape iff sq > 4.0.
  - Escape has priority: go to DONE with out_iter = cnt, escaped = 1, overflow = 0.
  - Else if cnt == limit: go to DONE with out_iter = cnt, escaped = 0.
  - Else update: zr' = m_rr - m_ii + cr, zi' = 2*m_ri + ci, each computed with 2 guard integer bits and truncated to 2.(WIDTH-2) (drop LSBs; no rounding). Then cnt <= cnt + 1.
- Limit 0: one RUN cycle, then DONE with out_iter = 0, escaped = 0.
- The limit equal to 2^CNT_W - 1 is legal; cnt never wraps because the limit check precedes the increment.
- DONE: out_valid = 1; result registers stay stable until out_ready. On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE, so a new request is accepted no earlier than the cycle after the handshake.
- Latency: request handshake to out_valid = (number of updates + 2) cycles.
- Outputs are registered; no combinational path from in_* or out_ready to out_*. Exception: in_ready and out_valid are decoded directly from state.

Optional Feature:
- Macro: MANDELBROT_OVERFLOW_DETECT_EN.
- Defined:
  - If zr' or zi', before truncation, lies outside [-2, 2), the update is discarded.
  - Go to DONE with out_iter = cnt + 1, escaped = 1, out_overflow = 1.
  - The escape and limit checks on the current z still take priority.
- Undefined:
  - Out-of-range results wrap modulo 4 and iteration continues.
  - out_overflow is tied to 0.

Decomposition:
- Shared package mandelbrot_pkg:
  - state encoding (IDLE, RUN, DONE);
  - fixed-point helper constants: FRAC_BITS = WIDTH-2, ONE = 1 << FRAC_BITS, FOUR_SQ = 4 << (2*FRAC_BITS).
- One sub-module, mandelbrot_step: purely combinational; takes cr, ci, zr, zi and returns zr', zi', escape, overflow. The iteration unit holds the FSM, the registers and the handshakes.

Test Plan:
- WIDTH=8, c = (0, 0), limit 15: out_iter = 15, escaped = 0, out_valid 17 cycles after the request handshake.
- c = (1.5, 1.5), limit 15: z1 has |z|^2 = 4.5, so out_iter = 1, escaped = 1, overflow = 0.
- c = (-1.0, 0), limit 7: z cycles 0/-1 with no escape, so out_iter = 7, escaped = 0.
- c = (1.25, 0), limit 15:
  - Feature on: zr2 = 2.8125 overflows, so out_iter = 2, escaped = 1, overflow = 1.
  - Feature off: zr2 wraps to -1.1875 and iteration continues; check against a bit-exact model.
- Limit 0 -> out_iter = 0, escaped = 0 after 2 cycles. Hold out_ready = 0 for 5 cycles: outputs stable, in_ready = 0, a new in_valid is ignored.
- Assert rst mid-RUN: all outputs return to reset values immediately. The next request, c = (1.5, 1.5), completes normally.
